pipe_stage_buf: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake and optional 2-entry skid.

---
 rtl/pipe_stage_buf_pkg.sv | 73 +++++++
 rtl/pipe_stage_buf_slot.sv | 32 +++
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline-stage buffer.
//  - buf_state_t : control state of the buffer (EMPTY / ONE / TWO)
//  - EX/MEM bundle layout: field offsets, widths and total width (EXMEM_W)
//  - EXMEM_NOP   : all-zero bundle (we=0, aluop=NOP), used as the bubble
//  - exmem_pack / exmem_unpack : convert between the field struct and the flat bus
//  - occ_of      : entry count held in a given state
package pipe_stage_buf_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_t;

   localparam int EXMEM_REG1_LSB  = 0;
   localparam int EXMEM_REG1_W    = 32;
   localparam int EXMEM_ADDR_LSB  = 32;
   localparam int EXMEM_ADDR_W    = 32;
   localparam int EXMEM_ALUOP_LSB = 64;
   localparam int EXMEM_ALUOP_W   = 8;
   localparam int EXMEM_WE_LSB    = 72;
   localparam int EXMEM_WDATA_LSB = 73;
   localparam int EXMEM_WDATA_W   = 32;
   localparam int EXMEM_WADDR_LSB = 105;
   localparam int EXMEM_WADDR_W   = 5;
   localparam int EXMEM_W         = 110;

   localparam logic [EXMEM_ALUOP_W-1:0] ALUOP_NOP = '0;
   localparam logic [EXMEM_W-1:0]       EXMEM_NOP = '0;

   typedef struct packed {
      logic [EXMEM_WADDR_W-1:0] waddr;
      logic [EXMEM_WDATA_W-1:0] wdata;
      logic                     we;
      logic [EXMEM_ALUOP_W-1:0] aluop;
      logic [EXMEM_ADDR_W-1:0]  addr;
      logic [EXMEM_REG1_W-1:0]  reg1;
   } exmem_t;

   function automatic logic [EXMEM_W-1:0] exmem_pack(input exmem_t f);
      logic [EXMEM_W-1:0] v;
      v = '0;
      v[EXMEM_REG1_LSB  +: EXMEM_REG1_W]  = f.reg1;
      v[EXMEM_ADDR_LSB  +: EXMEM_ADDR_W]  = f.addr;
      v[EXMEM_ALUOP_LSB +: EXMEM_ALUOP_W] = f.aluop;
      v[EXMEM_WE_LSB]                     = f.we;
      v[EXMEM_WDATA_LSB +: EXMEM_WDATA_W] = f.wdata;
      v[EXMEM_WADDR_LSB +: EXMEM_WADDR_W] = f.waddr;
      return v;
   endfunction

   function automatic exmem_t exmem_unpack(input logic [EXMEM_W-1:0] v);
      exmem_t f;
      f.reg1  = v[EXMEM_REG1_LSB  +: EXMEM_REG1_W];
      f.addr  = v[EXMEM_ADDR_LSB  +: EXMEM_ADDR_W];
      f.aluop = v[EXMEM_ALUOP_LSB +: EXMEM_ALUOP_W];
      f.we    = v[EXMEM_WE_LSB];
      f.wdata = v[EXMEM_WDATA_LSB +: EXMEM_WDATA_W];
      f.waddr = v[EXMEM_WADDR_LSB +: EXMEM_WADDR_W];
      return f;
   endfunction

   function automatic logic [1:0] occ_of(input buf_state_t s);
      logic [1:0] n;
      case (s)
         ST_ONE:  n = 2'd1;
         ST_TWO:  n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// pipe_slot: one payload entry of the stage buffer.
// Ports:
//  clk     in   1       clock
//  i_clr   in   1       synchronous clear (reset or flush), wins over i_load
//  i_load  in   1       capture i_data on this edge
//  i_data  in   DATA_W  value to capture
//  o_data  out  DATA_W  held value
module pipe_slot
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W = EXMEM_W
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-stage register with valid/ready handshake.
// DEPTH=1 is a plain register whose in_ready_o depends combinationally on
// out_ready_i; DEPTH=2 adds a skid entry so in_ready_o comes only from state.
// Output payload is BUBBLE_VAL whenever out_valid_o is low.
// Ports:
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high, highest priority
//  flush_i      in   1       synchronous flush, discards all held entries
//  in_valid_i   in   1       producer offers a beat
//  in_ready_o   out  1       buffer accepts a beat this cycle
//  in_data_i    in   DATA_W  producer payload
//  out_valid_o  out  1       out_data_o carries a beat
//  out_ready_i  in   1       consumer takes the beat this cycle
//  out_data_o   out  DATA_W  payload to next stage
//  occ_o        out  2       entries held
//
// state    | meaning
// ST_EMPTY | no entries held, output is the bubble
// ST_ONE   | main entry holds the head beat
// ST_TWO   | main holds the head beat, skid holds the next one (DEPTH=2 only)
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int                DATA_W     = EXMEM_W,
   parameter int                DEPTH      = 2,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occ_o
);

   if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH must be 1 or 2, got %0d", DEPTH);
   end

   buf_state_t        r_state;
   buf_state_t        w_state_nxt;
   logic              w_clr;
   logic              w_accept;
   logic              w_retire;
   logic              w_main_load;
   logic              w_skid_load;
   logic [DATA_W-1:0] w_main_d;
   logic [DATA_W-1:0] w_main_q;
   logic [DATA_W-1:0] w_skid_q;

   assign w_clr       = rst | flush_i;
   assign out_valid_o = (r_state != ST_EMPTY);
   assign w_retire    = out_valid_o & out_ready_i;

   // DEPTH=2: ready is a pure function of the state register, so no path
   // from out_ready_i. DEPTH=1: a full entry can be replaced while it retires.
   assign in_ready_o = (DEPTH == 1) ? ((r_state == ST_EMPTY) | out_ready_i)
                                    : (r_state != ST_TWO);
   assign w_accept   = in_valid_i & in_ready_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      if (flush_i) begin
         // A beat offered in the flush cycle is dropped; a retire still completes.
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && w_retire) begin
                  w_main_load = 1'b1;
               end else if (w_retire) begin
                  w_state_nxt = ST_EMPTY;
               end else if (w_accept && (DEPTH == 2)) begin
                  // Main is stalled and must stay stable, so the new beat parks in skid.
                  w_state_nxt = ST_TWO;
                  w_skid_load = 1'b1;
               end
            end
            ST_TWO: begin
               if (w_retire) begin
                  w_state_nxt = ST_ONE;
                  w_main_load = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Main reloads from skid when draining TWO, otherwise from the producer.
   assign w_main_d = (r_state == ST_TWO) ? w_skid_q : in_data_i;

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk    (clk),
      .i_clr  (w_clr),
      .i_load (w_main_load),
      .i_data (w_main_d),
      .o_data (w_main_q)
   );

   if (DEPTH == 2) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W)) u_skid (
         .clk    (clk),
         .i_clr  (w_clr),
         .i_load (w_skid_load),
         .i_data (in_data_i),
         .o_data (w_skid_q)
      );
   end else begin : g_no_skid
      assign w_skid_q = '0;
   end

   assign out_data_o = out_valid_o ? w_main_q : BUBBLE_VAL;
   assign occ_o      = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

   localparam int W = 110;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] in_data;

   logic         in_ready_2, out_valid_2;
   logic [W-1:0] out_data_2;
   logic [1:0]   occ_2;
   logic         in_ready_1, out_valid_1;
   logic [W-1:0] out_data_1;
   logic [1:0]   occ_1;

   int n_pass   = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(W), .DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready_2), .in_data_i(in_data),
      .out_valid_o(out_valid_2), .out_ready_i(out_ready), .out_data_o(out_data_2),
      .occ_o(occ_2)
   );

   pipe_stage_buf #(.DATA_W(W), .DEPTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready_1), .in_data_i(in_data),
      .out_valid_o(out_valid_1), .out_ready_i(out_ready), .out_data_o(out_data_1),
      .occ_o(occ_1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'(32'h55); out_ready = 1'b0;
      step();
      step();
      n_checks++; if (out_valid_2 !== 1'b0) $display("FAIL rst_valid2: got %b want 0", out_valid_2); else n_pass++;
      n_checks++; if (out_data_2 !== '0) $display("FAIL rst_data2: got %h want 0", out_data_2); else n_pass++;
      n_checks++; if (occ_2 !== 2'd0) $display("FAIL rst_occ2: got %0d want 0", occ_2); else n_pass++;
      n_checks++; if (in_ready_2 !== 1'b1) $display("FAIL rst_ready2: got %b want 1", in_ready_2); else n_pass++;
      n_checks++; if (out_valid_1 !== 1'b0) $display("FAIL rst_valid1: got %b want 0", out_valid_1); else n_pass++;
      n_checks++; if (out_data_1 !== '0) $display("FAIL rst_data1: got %h want 0", out_data_1); else n_pass++;
      n_checks++; if (occ_1 !== 2'd0) $display("FAIL rst_occ1: got %0d want 0", occ_1); else n_pass++;
      n_checks++; if (in_ready_1 !== 1'b1) $display("FAIL rst_ready1: got %b want 1", in_ready_1); else n_pass++;
      rst = 1'b0; in_valid = 1'b0;
      step();
      n_checks++; if (out_valid_2 !== 1'b0) $display("FAIL post_rst_valid2: got %b want 0", out_valid_2); else n_pass++;
      n_checks++; if (out_valid_1 !== 1'b0) $display("FAIL post_rst_valid1: got %b want 0", out_valid_1); else n_pass++;
   endtask

   task automatic test_streaming();
      logic [W-1:0] exp;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = W'(32'h11 + i);
         in_valid = 1'b1; in_data = exp;
         step();
         n_checks++; if (out_valid_2 !== 1'b1 || out_data_2 !== exp)
            $display("FAIL stream2[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid_2, out_data_2, exp); else n_pass++;
         n_checks++; if (out_valid_1 !== 1'b1 || out_data_1 !== exp)
            $display("FAIL stream1[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid_1, out_data_1, exp); else n_pass++;
         n_checks++; if (in_ready_2 !== 1'b1) $display("FAIL stream_ready2[%0d]: got %b want 1", i, in_ready_2); else n_pass++;
      end
      in_valid = 1'b0;
      step();
      n_checks++; if (out_valid_2 !== 1'b0 || out_data_2 !== '0)
         $display("FAIL stream_end2: got v=%b d=%h want v=0 d=0", out_valid_2, out_data_2); else n_pass++;
      n_checks++; if (out_valid_1 !== 1'b0 || out_data_1 !== '0)
         $display("FAIL stream_end1: got v=%b d=%h want v=0 d=0", out_valid_1, out_data_1); else n_pass++;
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'hA1);
      step();
      n_checks++; if (occ_2 !== 2'd1 || in_ready_2 !== 1'b1)
         $display("FAIL bp_a1: got occ=%0d rdy=%b want occ=1 rdy=1", occ_2, in_ready_2); else n_pass++;
      in_data = W'(32'hA2);
      step();
      n_checks++; if (occ_2 !== 2'd2 || in_ready_2 !== 1'b0)
         $display("FAIL bp_a2: got occ=%0d rdy=%b want occ=2 rdy=0", occ_2, in_ready_2); else n_pass++;
      in_data = W'(32'hA3);
      step();
      n_checks++; if (occ_2 !== 2'd2 || in_ready_2 !== 1'b0 || out_data_2 !== W'(32'hA1))
         $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a1", occ_2, in_ready_2, out_data_2); else n_pass++;
      out_ready = 1'b1;
      step();
      n_checks++; if (out_data_2 !== W'(32'hA2) || occ_2 !== 2'd1 || in_ready_2 !== 1'b1)
         $display("FAIL bp_rel_a2: got d=%h occ=%0d rdy=%b want d=a2 occ=1 rdy=1", out_data_2, occ_2, in_ready_2); else n_pass++;
      step();
      n_checks++; if (out_data_2 !== W'(32'hA3) || out_valid_2 !== 1'b1)
         $display("FAIL bp_rel_a3: got v=%b d=%h want v=1 d=a3", out_valid_2, out_data_2); else n_pass++;
      in_valid = 1'b0;
      step();
      n_checks++; if (out_valid_2 !== 1'b0 || occ_2 !== 2'd0)
         $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", out_valid_2, occ_2); else n_pass++;
      n_checks++; if (out_valid_1 !== 1'b0) $display("FAIL bp_drain1: got v=%b want 0", out_valid_1); else n_pass++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h01);
      step();
      in_data = W'(32'h02);
      step();
      n_checks++; if (occ_2 !== 2'd2) $display("FAIL fl_fill: got occ=%0d want 2", occ_2); else n_pass++;
      in_data = W'(32'hBB); flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (occ_2 !== 2'd0 || out_valid_2 !== 1'b0 || out_data_2 !== '0 || in_ready_2 !== 1'b1)
         $display("FAIL fl_empty2: got occ=%0d v=%b d=%h rdy=%b want 0 0 0 1", occ_2, out_valid_2, out_data_2, in_ready_2); else n_pass++;
      n_checks++; if (occ_1 !== 2'd0 || out_valid_1 !== 1'b0 || out_data_1 !== '0 || in_ready_1 !== 1'b1)
         $display("FAIL fl_empty1: got occ=%0d v=%b d=%h rdy=%b want 0 0 0 1", occ_1, out_valid_1, out_data_1, in_ready_1); else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (out_valid_2 !== 1'b0 || out_valid_1 !== 1'b0)
            $display("FAIL fl_no_bb[%0d]: got v2=%b v1=%b want 0 0", i, out_valid_2, out_valid_1); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h31);
      step();
      in_data = W'(32'h32);
      step();
      n_checks++; if (occ_2 !== 2'd2) $display("FAIL rm_fill: got occ=%0d want 2", occ_2); else n_pass++;
      in_data = W'(32'h33); rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      step();
      n_checks++; if (occ_2 !== 2'd0 || out_valid_2 !== 1'b0 || out_data_2 !== '0)
         $display("FAIL rm_empty2: got occ=%0d v=%b d=%h want 0 0 0", occ_2, out_valid_2, out_data_2); else n_pass++;
      n_checks++; if (occ_1 !== 2'd0 || out_valid_1 !== 1'b0)
         $display("FAIL rm_empty1: got occ=%0d v=%b want 0 0", occ_1, out_valid_1); else n_pass++;
   endtask

   task automatic test_depth1();
      out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'hC1);
      step();
      n_checks++; if (out_data_1 !== W'(32'hC1) || occ_1 !== 2'd1)
         $display("FAIL d1_full: got d=%h occ=%0d want d=c1 occ=1", out_data_1, occ_1); else n_pass++;
      n_checks++; if (in_ready_1 !== 1'b0) $display("FAIL d1_stall_ready: got %b want 0", in_ready_1); else n_pass++;
      out_ready = 1'b1; in_data = W'(32'hC2);
      #1;
      n_checks++; if (in_ready_1 !== 1'b1) $display("FAIL d1_pass_ready: got %b want 1", in_ready_1); else n_pass++;
      step();
      n_checks++; if (out_data_1 !== W'(32'hC2) || occ_1 !== 2'd1 || out_valid_1 !== 1'b1)
         $display("FAIL d1_reload: got d=%h occ=%0d v=%b want d=c2 occ=1 v=1", out_data_1, occ_1, out_valid_1); else n_pass++;
      n_checks++; if (out_data_2 !== W'(32'hC2) || occ_2 !== 2'd1)
         $display("FAIL d2_reload: got d=%h occ=%0d want d=c2 occ=1", out_data_2, occ_2); else n_pass++;
      in_valid = 1'b0;
      step();
      n_checks++; if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0)
         $display("FAIL d1_drain: got v1=%b v2=%b want 0 0", out_valid_1, out_valid_2); else n_pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] q2[$];
      logic [W-1:0] q1[$];
      logic [W-1:0] exp2, exp1, last_in, prev_d2, prev_d1;
      logic acc2, acc1, ret2, ret1, stall2, stall1;
      int unsigned seq;
      acc2 = 1'b0; acc1 = 1'b0; ret2 = 1'b0; ret1 = 1'b0;
      stall2 = 1'b0; stall1 = 1'b0; prev_d2 = '0; prev_d1 = '0;
      last_in = '0; seq = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if (ret2) void'(q2.pop_front());
         if (acc2) q2.push_back(last_in);
         if (ret1) void'(q1.pop_front());
         if (acc1) q1.push_back(last_in);
         #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = W'(seq);
         seq++;
         #1;
         exp2 = (q2.size() != 0) ? q2[0] : '0;
         exp1 = (q1.size() != 0) ? q1[0] : '0;
         n_checks++; if (out_valid_2 !== (q2.size() != 0) || out_data_2 !== exp2 || occ_2 !== 2'(q2.size()))
            $display("FAIL rnd2[%0d]: got v=%b d=%h occ=%0d want v=%b d=%h occ=%0d", c, out_valid_2, out_data_2, occ_2, (q2.size() != 0), exp2, q2.size()); else n_pass++;
         n_checks++; if (in_ready_2 !== (q2.size() < 2))
            $display("FAIL rnd_ready2[%0d]: got %b want %b", c, in_ready_2, (q2.size() < 2)); else n_pass++;
         n_checks++; if (out_valid_1 !== (q1.size() != 0) || out_data_1 !== exp1 || occ_1 !== 2'(q1.size()))
            $display("FAIL rnd1[%0d]: got v=%b d=%h occ=%0d want v=%b d=%h occ=%0d", c, out_valid_1, out_data_1, occ_1, (q1.size() != 0), exp1, q1.size()); else n_pass++;
         n_checks++; if (in_ready_1 !== ((q1.size() == 0) || out_ready))
            $display("FAIL rnd_ready1[%0d]: got %b want %b", c, in_ready_1, ((q1.size() == 0) || out_ready)); else n_pass++;
         if (stall2) begin
            n_checks++; if (out_data_2 !== prev_d2)
               $display("FAIL rnd_stable2[%0d]: got %h want %h", c, out_data_2, prev_d2); else n_pass++;
         end
         if (stall1) begin
            n_checks++; if (out_data_1 !== prev_d1)
               $display("FAIL rnd_stable1[%0d]: got %h want %h", c, out_data_1, prev_d1); else n_pass++;
         end
         acc2    = in_valid && in_ready_2;
         acc1    = in_valid && in_ready_1;
         ret2    = out_valid_2 && out_ready;
         ret1    = out_valid_1 && out_ready;
         stall2  = out_valid_2 && !out_ready;
         stall1  = out_valid_1 && !out_ready;
         prev_d2 = out_data_2;
         prev_d1 = out_data_1;
         last_in = in_data;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #1;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      test_depth1();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
